// File: rtl/ifx_dig_filter_mc.sv
// ifx_dig_filter_mc: multi-channel digital deglitch filter. Each channel has a
// synchroniser, a length-qualified toggle filter, edge-selective interrupt
// status (W1C), an interrupt mask and a shared single-cycle interrupt pulse.
module ifx_dig_filter_mc #(
  parameter int FILT_NB     = 8,
  parameter int AWIDTH      = 8,
  parameter int DWIDTH      = 8,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               acc_en_i,
  input  logic               wr_en_i,
  input  logic [AWIDTH-1:0]  addr_i,
  input  logic [DWIDTH-1:0]  wdata_i,
  output logic [DWIDTH-1:0]  rdata_o,
  input  logic [FILT_NB-1:0] data_in,
  output logic [FILT_NB-1:0] data_out,
  output logic               int_pulse_out
);

  localparam int CFG_W     = CNT_W + 3;
  localparam int ADDR_STAT = 'h40;
  localparam int ADDR_MASK = 'h60;
  localparam int ADDR_DOUT = 'h80;

  logic [SYNC_STAGES-1:0][FILT_NB-1:0] sync_q, sync_d;
  logic [FILT_NB-1:0] samp;
  logic [CFG_W-1:0]   cfg_q [FILT_NB];
  logic [CFG_W-1:0]   cfg_d [FILT_NB];
  logic [CNT_W-1:0]   cnt_q [FILT_NB];
  logic [CNT_W-1:0]   cnt_d [FILT_NB];
  logic [FILT_NB-1:0] out_q, out_d;
  logic [FILT_NB-1:0] status_q, status_d;
  logic [FILT_NB-1:0] mask_q, mask_d;
  logic [FILT_NB-1:0] event_s;
  logic [FILT_NB-1:0] w1c;
  logic [DWIDTH-1:0]  rdata_q, rdata_d, rd_word;
  logic               pulse_q, pulse_d;
  logic               wr_acc, rd_acc;

  // Toggle threshold: a length of zero behaves like a length of one.
  function automatic logic [CNT_W-1:0] thr_of(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  assign samp = sync_q[SYNC_STAGES-1];

  // Synchroniser shift, per-channel filter counters and qualified edge events.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], data_in};
    out_d   = out_q;
    event_s = '0;
    for (int ch = 0; ch < FILT_NB; ch++) begin
      cnt_d[ch] = '0;
      if (cfg_q[ch][CNT_W+2] && (samp[ch] != out_q[ch])) begin
        if (cnt_q[ch] >= thr_of(cfg_q[ch][CNT_W-1:0])) begin
          out_d[ch]   = samp[ch];
          event_s[ch] = samp[ch] ? cfg_q[ch][CNT_W] : cfg_q[ch][CNT_W+1];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
    status_d = (status_q & ~w1c) | event_s;
    pulse_d  = |(event_s & mask_q);
  end

  // Register bus decode: config/mask writes, W1C clear vector and read mux.
  always_comb begin
    wr_acc  = acc_en_i & wr_en_i;
    rd_acc  = acc_en_i & ~wr_en_i;
    mask_d  = mask_q;
    w1c     = '0;
    rd_word = '0;
    for (int ch = 0; ch < FILT_NB; ch++) begin
      cfg_d[ch] = cfg_q[ch];
      if (wr_acc && (addr_i == AWIDTH'(ch)))
        cfg_d[ch] = wdata_i[CFG_W-1:0];
      if (wr_acc && (addr_i == AWIDTH'(ADDR_STAT + ch / DWIDTH)))
        w1c[ch] = wdata_i[ch % DWIDTH];
      if (wr_acc && (addr_i == AWIDTH'(ADDR_MASK + ch / DWIDTH)))
        mask_d[ch] = wdata_i[ch % DWIDTH];
      if (addr_i == AWIDTH'(ch))
        rd_word[CFG_W-1:0] = cfg_q[ch];
      if (addr_i == AWIDTH'(ADDR_STAT + ch / DWIDTH))
        rd_word[ch % DWIDTH] = status_q[ch];
      if (addr_i == AWIDTH'(ADDR_MASK + ch / DWIDTH))
        rd_word[ch % DWIDTH] = mask_q[ch];
      if (addr_i == AWIDTH'(ADDR_DOUT + ch / DWIDTH))
        rd_word[ch % DWIDTH] = out_q[ch];
    end
    rdata_d = rd_acc ? rd_word : rdata_q;
  end

  // All state registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      out_q    <= '0;
      status_q <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      pulse_q  <= 1'b0;
      for (int ch = 0; ch < FILT_NB; ch++) begin
        cfg_q[ch] <= '0;
        cnt_q[ch] <= '0;
      end
    end else begin
      sync_q   <= sync_d;
      out_q    <= out_d;
      status_q <= status_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      pulse_q  <= pulse_d;
      for (int ch = 0; ch < FILT_NB; ch++) begin
        cfg_q[ch] <= cfg_d[ch];
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign data_out      = out_q;
  assign rdata_o       = rdata_q;
  assign int_pulse_out = pulse_q;

endmodule
